fifo_wptr_wstatus: RTL and testbench

Write-side pointer and status controller for the asynchronous FIFO, and the parametrised successor to the basic write-pointer/full block. It keeps the binary and Gray write pointers and drives the memory write address and enable. Besides the full flag it reports fill level, free space, a programmable almost-full flag and a sticky overflow error, all derived from the read pointer after it has been synchronised into the write clock domain.

---
 rtl/fifo_wptr_wstatus.sv | 70 +++++++
 tb/tb_fifo_wptr_wstatus.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/fifo_wptr_wstatus.sv
// Write-side pointer and status controller for the asynchronous FIFO.
// Tracks binary/Gray write pointers and derives full, almost-full, fill level, free space and overflow.
module fifo_wptr_wstatus #(
  parameter int Address = 3
) (
  input  logic               Wclk,
  input  logic               Wrst,
  input  logic               Winc,
  input  logic [Address:0]   Wq2_rptr,
  input  logic [Address:0]   Wafull_th,
  input  logic               Wovf_clr,
  output logic               Wen,
  output logic [Address-1:0] Wadder,
  output logic [Address:0]   Wptr,
  output logic               Wfull,
  output logic               Wafull,
  output logic [Address:0]   Wcount,
  output logic [Address:0]   Wfree,
  output logic               Wovf
);

  localparam logic [Address:0] DEPTH = (Address+1)'(1) << Address;

  logic [Address:0] wbin;
  logic [Address:0] wbin_next;
  logic [Address:0] wgray_next;
  logic [Address:0] rbin;
  logic [Address:0] count_next;

  assign Wen    = Winc & ~Wfull;
  assign Wadder = wbin[Address-1:0];

  // Each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    rbin = '0;
    for (int unsigned i = 0; i <= Address; i++) begin
      rbin[i] = ^(Wq2_rptr >> i);
    end
  end

  always_comb begin
    wbin_next  = wbin + {{Address{1'b0}}, Wen};
    wgray_next = (wbin_next >> 1) ^ wbin_next;
    count_next = wbin_next - rbin;
  end

  always_ff @(posedge Wclk or posedge Wrst) begin
    if (Wrst) begin
      wbin   <= '0;
      Wptr   <= '0;
      Wcount <= '0;
      Wfree  <= DEPTH;
      Wfull  <= 1'b0;
      Wafull <= 1'b0;
      Wovf   <= 1'b0;
    end else begin
      wbin   <= wbin_next;
      Wptr   <= wgray_next;
      Wcount <= count_next;
      Wfree  <= DEPTH - count_next;
      Wfull  <= (count_next == DEPTH);
      Wafull <= (Wafull_th != '0) && (count_next >= Wafull_th);
      if (Winc && Wfull)
        Wovf <= 1'b1;
      else if (Wovf_clr)
        Wovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fifo_wptr_wstatus.sv
// Directed self-checking bench for fifo_wptr_wstatus with Address = 3 (DEPTH = 8).
module tb_fifo_wptr_wstatus;

  logic       Wclk = 1'b0;
  logic       Wrst = 1'b0;
  logic       Winc = 1'b0;
  logic [3:0] Wq2_rptr = '0;
  logic [3:0] Wafull_th = 4'd6;
  logic       Wovf_clr = 1'b0;
  logic       Wen;
  logic [2:0] Wadder;
  logic [3:0] Wptr;
  logic       Wfull;
  logic       Wafull;
  logic [3:0] Wcount;
  logic [3:0] Wfree;
  logic       Wovf;

  int total = 0;
  int bad   = 0;

  fifo_wptr_wstatus #(.Address(3)) dut (
    .Wclk(Wclk), .Wrst(Wrst), .Winc(Winc), .Wq2_rptr(Wq2_rptr),
    .Wafull_th(Wafull_th), .Wovf_clr(Wovf_clr), .Wen(Wen), .Wadder(Wadder),
    .Wptr(Wptr), .Wfull(Wfull), .Wafull(Wafull), .Wcount(Wcount),
    .Wfree(Wfree), .Wovf(Wovf)
  );

  always #5 Wclk = ~Wclk;

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Wclk);
    #1;
  endtask

  function automatic logic [3:0] gray(input int v);
    logic [3:0] b;
    b = 4'(v);
    return b ^ (b >> 1);
  endfunction

  task automatic do_reset();
    Winc = 1'b0;
    Wovf_clr = 1'b0;
    Wq2_rptr = '0;
    Wrst = 1'b1;
    tick();
    Wrst = 1'b0;
  endtask

  // Eight writes with the read pointer held at zero, checking the almost-full threshold each step.
  task automatic fill8(input logic [3:0] th);
    Wafull_th = th;
    for (int k = 0; k < 8; k++) begin
      Winc = 1'b1;
      #1;
      chk("fill_wen", 32'(Wen), 32'd1);
      chk("fill_wadder", 32'(Wadder), 32'(k));
      tick();
      chk("fill_wcount", 32'(Wcount), 32'(k + 1));
      chk("fill_wafull", 32'(Wafull), 32'((th != 0) && (k + 1 >= int'(th))));
      chk("fill_wfull", 32'(Wfull), 32'(k == 7));
    end
    Winc = 1'b0;
  endtask

  initial begin
    #1;
    Wrst = 1'b1;
    Winc = 1'b1;
    #2;
    chk("rst_wptr", 32'(Wptr), 32'd0);
    chk("rst_wfull", 32'(Wfull), 32'd0);
    chk("rst_wafull", 32'(Wafull), 32'd0);
    chk("rst_wcount", 32'(Wcount), 32'd0);
    chk("rst_wfree", 32'(Wfree), 32'd8);
    chk("rst_wadder", 32'(Wadder), 32'd0);
    chk("rst_wovf", 32'(Wovf), 32'd0);
    chk("rst_wen", 32'(Wen), 32'd1);
    tick();
    Winc = 1'b0;
    Wrst = 1'b0;
    tick();
    chk("rst_hold_wcount", 32'(Wcount), 32'd0);

    fill8(4'd6);
    chk("full_wptr", 32'(Wptr), 32'hC);
    chk("full_wfree", 32'(Wfree), 32'd0);

    // Overflow attempt is dropped and sets the sticky flag.
    Winc = 1'b1;
    #1;
    chk("ovf_wen", 32'(Wen), 32'd0);
    chk("ovf_wadder", 32'(Wadder), 32'd0);
    tick();
    chk("ovf_set", 32'(Wovf), 32'd1);
    chk("ovf_wptr", 32'(Wptr), 32'hC);
    chk("ovf_wcount", 32'(Wcount), 32'd8);
    Wovf_clr = 1'b1;
    tick();
    chk("ovf_set_wins", 32'(Wovf), 32'd1);
    Winc = 1'b0;
    tick();
    chk("ovf_clr", 32'(Wovf), 32'd0);
    Wovf_clr = 1'b0;

    // Drain one slot, then pair every write with a read-pointer advance across the wrap.
    Wq2_rptr = gray(1);
    tick();
    chk("drain_wcount", 32'(Wcount), 32'd7);
    chk("drain_wfull", 32'(Wfull), 32'd0);
    for (int j = 2; j <= 9; j++) begin
      Wq2_rptr = gray(j);
      Winc = 1'b1;
      #1;
      chk("wrap_wen", 32'(Wen), 32'd1);
      chk("wrap_wadder", 32'(Wadder), 32'((8 + j - 2) % 8));
      tick();
      chk("wrap_wcount", 32'(Wcount), 32'd7);
      chk("wrap_wfull", 32'(Wfull), 32'd0);
    end
    chk("wrap_wptr_zero", 32'(Wptr), 32'd0);
    tick();
    chk("wrap_full_wcount", 32'(Wcount), 32'd8);
    chk("wrap_full_wfull", 32'(Wfull), 32'd1);
    chk("wrap_full_wptr", 32'(Wptr), 32'd1);
    Winc = 1'b0;

    // Free space after three writes and two reads.
    do_reset();
    Wafull_th = 4'd6;
    Winc = 1'b1;
    repeat (3) tick();
    Winc = 1'b0;
    Wq2_rptr = gray(2);
    tick();
    chk("free_wcount", 32'(Wcount), 32'd1);
    chk("free_wfree", 32'(Wfree), 32'd7);
    chk("free_wafull", 32'(Wafull), 32'd0);

    do_reset();
    fill8(4'd0);
    do_reset();
    fill8(4'd8);
    do_reset();
    fill8(4'd15);

    // Reset mid-burst clears everything before the next clock edge.
    do_reset();
    Wafull_th = 4'd3;
    Winc = 1'b1;
    repeat (5) tick();
    chk("burst_wcount", 32'(Wcount), 32'd5);
    chk("burst_wafull", 32'(Wafull), 32'd1);
    #1;
    Wrst = 1'b1;
    #1;
    chk("async_wcount", 32'(Wcount), 32'd0);
    chk("async_wptr", 32'(Wptr), 32'd0);
    chk("async_wfree", 32'(Wfree), 32'd8);
    chk("async_wadder", 32'(Wadder), 32'd0);
    chk("async_wafull", 32'(Wafull), 32'd0);
    chk("async_wen", 32'(Wen), 32'd1);
    tick();
    Wrst = 1'b0;
    #1;
    chk("resume_wadder", 32'(Wadder), 32'd0);
    tick();
    chk("resume_wcount", 32'(Wcount), 32'd1);
    chk("resume_wadder1", 32'(Wadder), 32'd1);
    Winc = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
